// File: rtl/alarm_controller.sv
// Car-alarm controller: arms, triggers and sounds the siren from ignition and
// door sensors, timing every delay in pulses of the shared 1 Hz enable.
module alarm_controller #(
   parameter int unsigned T_ARM_DELAY       = 6,
   parameter int unsigned T_DRIVER_DELAY    = 8,
   parameter int unsigned T_PASSENGER_DELAY = 15,
   parameter int unsigned T_ALARM_ON        = 10,
   parameter int unsigned CNT_W             = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       one_hz_enable,
   input  logic       ignition,
   input  logic       driver_door,
   input  logic       passenger_door,
   output logic       enable_siren,
   output logic       half_hz_enable,
   output logic       status,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_ARMED      = 3'd0,
      ST_TRIGGERED  = 3'd1,
      ST_ALARM      = 3'd2,
      ST_DISARMED   = 3'd3,
      ST_WAIT_DOOR  = 3'd4,
      ST_WAIT_CLOSE = 3'd5,
      ST_ARM_DELAY  = 3'd6
   } state_e;

   localparam logic [CNT_W-1:0] LD_ARM   = CNT_W'(T_ARM_DELAY);
   localparam logic [CNT_W-1:0] LD_DRV   = CNT_W'(T_DRIVER_DELAY);
   localparam logic [CNT_W-1:0] LD_PAS   = CNT_W'(T_PASSENGER_DELAY);
   localparam logic [CNT_W-1:0] LD_ALARM = CNT_W'(T_ALARM_ON);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             half_q;
   logic             any_door;
   logic             expire;

   assign any_door = driver_door | passenger_door;
   assign expire   = one_hz_enable && (timer_q == ONE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_ARMED;
         timer_q <= '0;
         half_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         if (one_hz_enable) half_q <= ~half_q;
      end
   end

   // Next state and timer; a load on a transition edge swallows any coincident pulse.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (ignition) begin
         state_d = ST_DISARMED;
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (driver_door) begin
                  state_d = ST_TRIGGERED;
                  timer_d = LD_DRV;
               end else if (passenger_door) begin
                  state_d = ST_TRIGGERED;
                  timer_d = LD_PAS;
               end
            end
            ST_TRIGGERED: begin
               if (expire) begin
                  state_d = ST_ALARM;
                  timer_d = LD_ALARM;
               end else if (one_hz_enable) begin
                  timer_d = timer_q - ONE;
               end
            end
            ST_ALARM: begin
               if (any_door) begin
                  timer_d = LD_ALARM;
               end else if (expire) begin
                  state_d = ST_ARMED;
               end else if (one_hz_enable) begin
                  timer_d = timer_q - ONE;
               end
            end
            ST_DISARMED:  state_d = ST_WAIT_DOOR;
            ST_WAIT_DOOR: if (driver_door) state_d = ST_WAIT_CLOSE;
            ST_WAIT_CLOSE: begin
               if (!any_door) begin
                  state_d = ST_ARM_DELAY;
                  timer_d = LD_ARM;
               end
            end
            ST_ARM_DELAY: begin
               if (any_door) begin
                  state_d = ST_WAIT_CLOSE;
               end else if (expire) begin
                  state_d = ST_ARMED;
               end else if (one_hz_enable) begin
                  timer_d = timer_q - ONE;
               end
            end
            default: state_d = ST_ARMED;
         endcase
      end
   end

   // Moore decode from registered state only.
   assign enable_siren   = (state_q == ST_ALARM);
   assign half_hz_enable = half_q;
   assign status         = (state_q == ST_ARMED) ? half_q :
                           ((state_q == ST_TRIGGERED) || (state_q == ST_ALARM));
   assign state          = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with immediate-assertion checks.
module tb_alarm_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic       one_hz_enable;
   logic       ignition;
   logic       driver_door;
   logic       passenger_door;
   logic       enable_siren;
   logic       half_hz_enable;
   logic       status;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   alarm_controller dut (
      .clock          (clock),
      .reset          (reset),
      .one_hz_enable  (one_hz_enable),
      .ignition       (ignition),
      .driver_door    (driver_door),
      .passenger_door (passenger_door),
      .enable_siren   (enable_siren),
      .half_hz_enable (half_hz_enable),
      .status         (status),
      .state          (state)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge with an optional 1 Hz pulse; outputs settle 1 time unit later.
   task automatic tick(input logic pulse);
      one_hz_enable = pulse;
      @(posedge clock);
      #1;
      one_hz_enable = 1'b0;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) tick(1'b1);
   endtask

   initial begin
      reset = 1'b1; one_hz_enable = 1'b0; ignition = 1'b0;
      driver_door = 1'b0; passenger_door = 1'b0;
      #12 reset = 1'b0;
      #1;
      check("rst_state", 8'(state), 8'd0);
      check("rst_siren", 8'(enable_siren), 8'd0);
      check("rst_half", 8'(half_hz_enable), 8'd0);
      check("rst_status", 8'(status), 8'd0);

      tick(1'b1);
      check("half1", 8'(half_hz_enable), 8'd1);
      check("status1", 8'(status), 8'd1);
      tick(1'b1);
      check("half2", 8'(half_hz_enable), 8'd0);
      check("status2", 8'(status), 8'd0);
      tick(1'b1);
      check("half3", 8'(half_hz_enable), 8'd1);
      check("status3", 8'(status), 8'd1);
      check("armed_idle", 8'(state), 8'd0);

      // Driver trigger: 8 pulses to alarm
      driver_door = 1'b1; tick(1'b0); driver_door = 1'b0;
      check("drv_trig", 8'(state), 8'd1);
      check("trig_status", 8'(status), 8'd1);
      pulses(7);
      check("drv_p7", 8'(state), 8'd1);
      check("drv_p7_siren", 8'(enable_siren), 8'd0);
      pulses(1);
      check("drv_p8", 8'(state), 8'd2);
      check("drv_p8_siren", 8'(enable_siren), 8'd1);
      check("alarm_status", 8'(status), 8'd1);

      // Door held open keeps the alarm going
      driver_door = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1'b1);
         check("hold_siren", 8'(enable_siren), 8'd1);
      end
      driver_door = 1'b0;
      pulses(9);
      check("close_p9", 8'(state), 8'd2);
      pulses(1);
      check("close_p10", 8'(state), 8'd0);
      check("close_p10_siren", 8'(enable_siren), 8'd0);

      // Passenger-only trigger: 15 pulses
      passenger_door = 1'b1; tick(1'b0); passenger_door = 1'b0;
      check("pas_trig", 8'(state), 8'd1);
      pulses(14);
      check("pas_p14", 8'(state), 8'd1);
      pulses(1);
      check("pas_p15", 8'(state), 8'd2);

      // Ignition from ALARM drops the siren
      ignition = 1'b1; tick(1'b0);
      check("alarm_ign", 8'(state), 8'd3);
      check("alarm_ign_siren", 8'(enable_siren), 8'd0);

      // Disarm path with a door reopened during arm delay
      ignition = 1'b0; tick(1'b0);
      check("wait_door", 8'(state), 8'd4);
      driver_door = 1'b1; tick(1'b0);
      check("wait_close", 8'(state), 8'd5);
      driver_door = 1'b0; tick(1'b0);
      check("arm_delay", 8'(state), 8'd6);
      pulses(3);
      driver_door = 1'b1; tick(1'b1);
      check("reopen", 8'(state), 8'd5);
      driver_door = 1'b0; tick(1'b0);
      check("arm_delay2", 8'(state), 8'd6);
      pulses(5);
      check("arm_p5", 8'(state), 8'd6);
      pulses(1);
      check("arm_p6", 8'(state), 8'd0);

      // Ignition in TRIGGERED with timer at 3
      driver_door = 1'b1; tick(1'b0); driver_door = 1'b0;
      pulses(5);
      check("trig_t3", 8'(state), 8'd1);
      ignition = 1'b1; tick(1'b0);
      check("trig_ign", 8'(state), 8'd3);
      check("trig_ign_siren", 8'(enable_siren), 8'd0);

      // Re-arm, then both doors with a coincident pulse
      ignition = 1'b0; tick(1'b0);
      driver_door = 1'b1; tick(1'b0);
      driver_door = 1'b0; tick(1'b0);
      pulses(6);
      check("rearm", 8'(state), 8'd0);
      driver_door = 1'b1; passenger_door = 1'b1; tick(1'b1);
      driver_door = 1'b0; passenger_door = 1'b0;
      check("both_trig", 8'(state), 8'd1);
      pulses(7);
      check("both_p7", 8'(state), 8'd1);
      pulses(1);
      check("both_p8", 8'(state), 8'd2);

      // Asynchronous reset between edges while in ALARM
      #2 reset = 1'b1;
      #1;
      check("async_siren", 8'(enable_siren), 8'd0);
      check("async_state", 8'(state), 8'd0);
      check("async_half", 8'(half_hz_enable), 8'd0);
      reset = 1'b0;
      tick(1'b0);
      check("post_rst_state", 8'(state), 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Sequential car-alarm controller that drives `siren_generator` (inputs `enable_siren`, `half_hz_enable`) and the status LED.
- Decides arm/disarm/trigger/alarm from ignition and door sensors.
- Times every delay by counting a 1 Hz enable pulse supplied by the shared timebase.
- Sits between the sensor synchronisers and the siren/LED drivers.

Parameters:
T_ARM_DELAY, 6, seconds from driver-door close to armed
T_DRIVER_DELAY, 8, seconds from driver-door open (armed) to alarm
T_PASSENGER_DELAY, 15, seconds from passenger-door open (armed) to alarm
T_ALARM_ON, 10, seconds siren stays on after all doors closed
CNT_W, 4, timer width; every T_* must be in 1..2^CNT_W-1

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
one_hz_enable  input  1  single-cycle pulse once per second
ignition  input  1  1 = ignition on (synchronised)
driver_door  input  1  1 = driver door open (synchronised)
passenger_door  input  1  1 = passenger door open (synchronised)
enable_siren  output  1  to siren_generator; 1 only in ALARM
half_hz_enable  output  1  toggles on each one_hz_enable pulse
status  output  1  status LED
state  output  3  current state code (debug)

Behaviour:
- Reset (async, high): state=ARMED (code 0), timer=0, half_hz_enable=0, enable_siren=0, status=0.
- All outputs are registered or Moore-decoded from registered state; no combinational path from inputs to outputs.
- half_hz_enable is free-running: it inverts on every clock edge where one_hz_enable=1, in all states.
- Timer rules:
  - Entering a timed state loads timer with that state's T.
  - On each one_hz_enable pulse: if timer==1 the state's expiry transition fires; otherwise timer decrements.
  - Timing is therefore exactly T pulses. Cycles without a pulse hold the timer.
- Priority in every state: ignition=1 overrides all else and goes to DISARMED on the next edge.
- States and transitions:
  - ARMED(0):
    - driver_door=1 -> TRIGGERED, load T_DRIVER_DELAY.
    - Otherwise passenger_door=1 -> TRIGGERED, load T_PASSENGER_DELAY.
    - Both doors open in the same cycle -> driver delay.
  - TRIGGERED(1): expiry -> ALARM, load T_ALARM_ON. Door activity does not change the timer.
  - ALARM(2):
    - Any door open -> timer reloads T_ALARM_ON every cycle and pulses are ignored.
    - Expiry with both doors closed -> ARMED.
  - DISARMED(3): ignition=0 -> WAIT_DOOR.
  - WAIT_DOOR(4): driver_door=1 -> WAIT_CLOSE.
  - WAIT_CLOSE(5): driver_door=0 and passenger_door=0 -> ARM_DELAY, load T_ARM_DELAY.
  - ARM_DELAY(6):
    - Any door open -> WAIT_CLOSE.
    - Expiry -> ARMED.
  - Code 7 is unreachable; if entered, go to ARMED next cycle.
- Outputs per state:
  - enable_siren = (state==ALARM).
  - status = half_hz_enable in ARMED; 1 in TRIGGERED and ALARM; 0 otherwise.
- Simultaneous events:
  - A transition and a one_hz_enable pulse on the same edge: the new state's timer is loaded and that pulse is not counted.
  - A door opening and expiry on the same edge in ALARM: the reload wins.
- Reset mid-alarm: siren off immediately (async), controller in ARMED.

Test Plan:
- Reset, all inputs 0, 3 one_hz pulses -> state=0, enable_siren=0, half_hz_enable sequence 1,0,1, status follows half_hz_enable.
- ARMED, driver_door pulse, 8 one_hz pulses -> TRIGGERED for pulses 1-7, ALARM (enable_siren=1, status=1) after the 8th pulse; passenger-only trigger instead needs 15 pulses.
- In ALARM, door held open 20 pulses -> siren stays 1. Close door, 10 pulses -> ARMED, enable_siren=0 after the 10th.
- TRIGGERED at timer=3, ignition=1 -> DISARMED next edge, enable_siren stays 0. Same check from ALARM: siren drops next edge.
- Disarm path: ignition 1->0, driver_door open then close, 6 pulses -> ARMED. Reopening a door at pulse 4 returns to WAIT_CLOSE; after closing, a full 6 pulses are required again.
- Both doors open in the same cycle from ARMED -> timer=8; one_hz_enable coincident with the transition edge is not counted; async reset asserted mid-clock in ALARM -> enable_siren=0 before the next edge.
